ef_smsdac_chk: RTL and testbench

// - Receive-side decoder/checker for the segmented mismatch-shaping DAC output bus d_out_3..d_out_0.
// - Reconstructs the analog-equivalent code each cycle and accumulates the error against the delayed 8-b source word.
// - Tracks per-segment unit-element imbalance and flags encoder misbehaviour.
// - Sits beside the DAC top, in the test harness and in the on-chip self-check path; it never drives the DAC.

---
 rtl/ef_smsdac_chk_pkg.sv | 36 +++
 rtl/ef_smsdac_dly.sv | 42 ++++
 rtl/ef_smsdac_chk.sv | 187 ++++++++++++++++++
 tb/tb_ef_smsdac_chk.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ef_smsdac_chk_pkg.sv
// ----------------------------------------------------------------------------
// ef_smsdac_chk_pkg
// Shared definitions for the segmented mismatch-shaping DAC checker:
//   - segment code encoding ({p, n} pairs, or {msb, carry} for segment 3)
//   - segment weights SEG3_W..SEG0_W in units of 1 LSB of the 8-b source word
//   - level decode and weighted contribution helpers
// ----------------------------------------------------------------------------
package ef_smsdac_chk_pkg;

  // Two-bit unit-element code of one segment.
  typedef enum logic [1:0] {
    SEG_IDLE = 2'b00,  // no element on
    SEG_DN   = 2'b01,  // n element on
    SEG_UP   = 2'b10,  // p element on
    SEG_FULL = 2'b11   // both elements on
  } seg_code_e;

  localparam logic [8:0] SEG3_W = 9'd128;
  localparam logic [8:0] SEG2_W = 9'd64;
  localparam logic [8:0] SEG1_W = 9'd32;
  localparam logic [8:0] SEG0_W = 9'd16;

  // Segments 2..0 carry imbalance counters; segment 3 does not.
  localparam int unsigned N_IMB = 3;

  // Element level: number of elements switched on (0, 1 or 2).
  function automatic logic [8:0] seg_level(input logic [1:0] c);
    return {8'b0, c[1]} + {8'b0, c[0]};
  endfunction

  // Weighted contribution of one segment to the reconstructed code.
  function automatic logic [8:0] seg_contrib(input logic [1:0] c, input logic [8:0] w);
    return seg_level(c) * w;
  endfunction

endpackage

// File: rtl/ef_smsdac_dly.sv
// ----------------------------------------------------------------------------
// ef_smsdac_dly
// W-bit x DEPTH shift register used to align the source word with the DAC
// output codes.
// Ports:
//   clk    in   clock
//   rst_b  in   synchronous active-low reset, clears every stage
//   en     in   1 = shift this cycle, 0 = hold
//   d      in   W  word entering stage 0
//   q      out  W  word from the last stage (d delayed DEPTH enabled samples)
// ----------------------------------------------------------------------------
module ef_smsdac_dly
  import ef_smsdac_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sr[i] <= '0;
      end
    end else if (en) begin
      sr[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/ef_smsdac_chk.sv
// ----------------------------------------------------------------------------
// ef_smsdac_chk
// Receive-side decoder/checker for the segmented mismatch-shaping DAC bus.
// Reconstructs the code from the segment outputs, accumulates the error
// against the LAT-delayed source word and tracks per-segment element
// imbalance. Purely observational; it never drives the DAC.
// Ports:
//   clk, rst_b        clock, synchronous active-low reset
//   en                1 = sample/update, 0 = hold all state
//   clr               clear acc, imb_*, err_cnt, flags (delay line kept)
//   d_ref   [7:0]     unsigned source word, same timing as DAC input
//   d_out_3 [1:0]     8x segment {msb, carry}
//   d_out_2..0 [1:0]  4x/2x/1x segment {p, n}
//   y_rec   [8:0]     registered reconstructed code
//   y_vld             delay line filled (LAT enabled samples taken)
//   acc     [ACC_W]   signed saturating sum of (d_ref_dly - y_rec)
//   imb_2..0 [IMB_W]  signed saturating imbalance counters
//   err_flag          sticky |acc| > ERR_BND
//   imb_flag          sticky any |imb_k| > IMB_MAX
//   err_cnt [15:0]    saturating count of cycles with |acc| > ERR_BND
// ----------------------------------------------------------------------------
module ef_smsdac_chk
  import ef_smsdac_chk_pkg::*;
#(
  parameter int unsigned LAT     = 3,
  parameter int unsigned ACC_W   = 12,
  parameter int unsigned ERR_BND = 32,
  parameter int unsigned IMB_W   = 4,
  parameter int unsigned IMB_MAX = 2
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    en,
  input  logic                    clr,
  input  logic [7:0]              d_ref,
  input  logic [1:0]              d_out_3,
  input  logic [1:0]              d_out_2,
  input  logic [1:0]              d_out_1,
  input  logic [1:0]              d_out_0,
  output logic [8:0]              y_rec,
  output logic                    y_vld,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [IMB_W-1:0] imb_2,
  output logic signed [IMB_W-1:0] imb_1,
  output logic signed [IMB_W-1:0] imb_0,
  output logic                    err_flag,
  output logic                    imb_flag,
  output logic [15:0]             err_cnt
);

  generate
    if (LAT < 1 || LAT > 7) begin : g_bad_lat
      $error("ef_smsdac_chk: LAT must be in 1..7");
    end
    if (ACC_W < 11) begin : g_bad_acc_w
      $error("ef_smsdac_chk: ACC_W must be at least 11");
    end
    if (IMB_W < 2) begin : g_bad_imb_w
      $error("ef_smsdac_chk: IMB_W must be at least 2");
    end
  endgenerate

  localparam logic [2:0] FILL_FULL = 3'(LAT);

  localparam logic signed [ACC_W:0]   ACC_HI = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   ACC_LO = -ACC_HI;
  localparam logic signed [ACC_W-1:0] ERR_HI = ACC_W'(ERR_BND);
  localparam logic signed [ACC_W-1:0] ERR_LO = -ERR_HI;

  localparam logic signed [IMB_W-1:0] IMB_TOP  = {1'b0, {(IMB_W-1){1'b1}}};
  localparam logic signed [IMB_W-1:0] IMB_BOT  = {1'b1, {(IMB_W-1){1'b0}}};
  localparam logic signed [IMB_W-1:0] IMB_ONE  = IMB_W'(1);
  localparam logic signed [IMB_W-1:0] IMB_LIM  = IMB_W'(IMB_MAX);
  localparam logic signed [IMB_W-1:0] IMB_NLIM = -IMB_LIM;

  logic [7:0]              d_ref_dly;
  logic [2:0]              fill;
  logic [8:0]              y_rec_comb;
  logic signed [9:0]       diff;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic                    acc_oob;
  logic [1:0]              seg_code [N_IMB];
  logic signed [IMB_W-1:0] imb_q    [N_IMB];
  logic signed [IMB_W-1:0] imb_d    [N_IMB];
  logic                    imb_oob;

  ef_smsdac_dly #(
    .DEPTH (LAT),
    .W     (8)
  ) u_dly (
    .clk   (clk),
    .rst_b (rst_b),
    .en    (en),
    .d     (d_ref),
    .q     (d_ref_dly)
  );

  assign y_rec_comb = seg_contrib(d_out_3, SEG3_W) + seg_contrib(d_out_2, SEG2_W)
                    + seg_contrib(d_out_1, SEG1_W) + seg_contrib(d_out_0, SEG0_W);

  // Error term uses the undelayed decode so acc and y_rec move on the same edge.
  always_comb begin
    diff    = $signed({2'b00, d_ref_dly}) - $signed({1'b0, y_rec_comb});
    acc_sum = $signed({acc[ACC_W-1], acc}) + $signed({{(ACC_W-9){diff[9]}}, diff});
    if (acc_sum > ACC_HI) begin
      acc_next = ACC_HI[ACC_W-1:0];
    end else if (acc_sum < ACC_LO) begin
      acc_next = ACC_LO[ACC_W-1:0];
    end else begin
      acc_next = acc_sum[ACC_W-1:0];
    end
    acc_oob = (acc_next > ERR_HI) || (acc_next < ERR_LO);
  end

  assign seg_code[0] = d_out_0;
  assign seg_code[1] = d_out_1;
  assign seg_code[2] = d_out_2;

  always_comb begin
    imb_oob = 1'b0;
    for (int unsigned k = 0; k < N_IMB; k++) begin
      imb_d[k] = imb_q[k];
      case (seg_code_e'(seg_code[k]))
        SEG_UP:  if (imb_q[k] != IMB_TOP) imb_d[k] = imb_q[k] + IMB_ONE;
        SEG_DN:  if (imb_q[k] != IMB_BOT) imb_d[k] = imb_q[k] - IMB_ONE;
        default: imb_d[k] = imb_q[k];
      endcase
      if ((imb_d[k] > IMB_LIM) || (imb_d[k] < IMB_NLIM)) begin
        imb_oob = 1'b1;
      end
    end
  end

  assign y_vld = (fill == FILL_FULL);

  // clr takes priority over the update but not over the fill/y_rec path,
  // so the delay line and y_vld stay consistent across a clear.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      fill     <= '0;
      y_rec    <= '0;
      acc      <= '0;
      err_flag <= 1'b0;
      imb_flag <= 1'b0;
      err_cnt  <= '0;
      for (int unsigned k = 0; k < N_IMB; k++) begin
        imb_q[k] <= '0;
      end
    end else begin
      if (en) begin
        y_rec <= y_rec_comb;
        if (fill != FILL_FULL) begin
          fill <= fill + 3'd1;
        end
      end
      if (clr) begin
        acc      <= '0;
        err_flag <= 1'b0;
        imb_flag <= 1'b0;
        err_cnt  <= '0;
        for (int unsigned k = 0; k < N_IMB; k++) begin
          imb_q[k] <= '0;
        end
      end else if (en && y_vld) begin
        acc <= acc_next;
        for (int unsigned k = 0; k < N_IMB; k++) begin
          imb_q[k] <= imb_d[k];
        end
        if (acc_oob) begin
          err_flag <= 1'b1;
          if (err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
          end
        end
        if (imb_oob) begin
          imb_flag <= 1'b1;
        end
      end
    end
  end

  assign imb_0 = imb_q[0];
  assign imb_1 = imb_q[1];
  assign imb_2 = imb_q[2];

endmodule

// File: tb/tb_ef_smsdac_chk.sv
// ----------------------------------------------------------------------------
// tb_ef_smsdac_chk
// Directed bench for ef_smsdac_chk (LAT=3, ACC_W=12, ERR_BND=32, IMB_W=4,
// IMB_MAX=2). Expected values are hand-derived constants.
// ----------------------------------------------------------------------------
module tb_ef_smsdac_chk;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              en;
  logic              clr;
  logic [7:0]        d_ref;
  logic [1:0]        d_out_3, d_out_2, d_out_1, d_out_0;
  logic [8:0]        y_rec;
  logic              y_vld;
  logic signed [11:0] acc;
  logic signed [3:0] imb_2, imb_1, imb_0;
  logic              err_flag, imb_flag;
  logic [15:0]       err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ef_smsdac_chk #(
    .LAT     (3),
    .ACC_W   (12),
    .ERR_BND (32),
    .IMB_W   (4),
    .IMB_MAX (2)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .en       (en),
    .clr      (clr),
    .d_ref    (d_ref),
    .d_out_3  (d_out_3),
    .d_out_2  (d_out_2),
    .d_out_1  (d_out_1),
    .d_out_0  (d_out_0),
    .y_rec    (y_rec),
    .y_vld    (y_vld),
    .acc      (acc),
    .imb_2    (imb_2),
    .imb_1    (imb_1),
    .imb_0    (imb_0),
    .err_flag (err_flag),
    .imb_flag (imb_flag),
    .err_cnt  (err_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic codes(input logic [1:0] c3, input logic [1:0] c2,
                       input logic [1:0] c1, input logic [1:0] c0);
    d_out_3 = c3;
    d_out_2 = c2;
    d_out_1 = c1;
    d_out_0 = c0;
  endtask

  initial begin
    // T1 reset with random inputs
    rst_b = 1'b0;
    en    = 1'($urandom);
    clr   = 1'($urandom);
    d_ref = 8'($urandom);
    codes(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    tick(2);
    check("rst_y_rec", int'(y_rec), 0);
    check("rst_y_vld", int'(y_vld), 0);
    check("rst_acc", int'(acc), 0);
    check("rst_imb_0", int'(imb_0), 0);
    check("rst_imb_2", int'(imb_2), 0);
    check("rst_err_flag", int'(err_flag), 0);
    check("rst_imb_flag", int'(imb_flag), 0);
    check("rst_err_cnt", int'(err_cnt), 0);

    // T2 decode during fill
    rst_b = 1'b1;
    en    = 1'b1;
    clr   = 1'b0;
    d_ref = 8'd0;
    codes(2'b11, 2'b10, 2'b01, 2'b00);
    tick(1);
    check("decode_352", int'(y_rec), 352);
    check("fill1_y_vld", int'(y_vld), 0);
    codes(2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    check("fill2_y_vld", int'(y_vld), 0);
    tick(1);
    check("fill3_y_vld", int'(y_vld), 1);
    check("fill_acc", int'(acc), 0);

    // T3 tracking: d_ref leads the matching codes by LAT
    d_ref = 8'd96;
    tick(3);
    codes(2'b00, 2'b10, 2'b01, 2'b00);
    tick(100);
    check("track_y_rec", int'(y_rec), 96);
    check("track_acc", int'(acc), 0);
    check("track_err_flag", int'(err_flag), 0);
    check("track_err_cnt", int'(err_cnt), 0);
    check("track_imb_2_sat", int'(imb_2), 7);
    check("track_imb_1_sat", int'(imb_1), -8);
    check("track_imb_flag", int'(imb_flag), 1);

    // clr with en: state cleared, y_vld kept
    clr = 1'b1;
    codes(2'b00, 2'b00, 2'b11, 2'b11);
    tick(1);
    clr = 1'b0;
    check("clr_acc", int'(acc), 0);
    check("clr_imb_2", int'(imb_2), 0);
    check("clr_imb_1", int'(imb_1), 0);
    check("clr_imb_flag", int'(imb_flag), 0);
    check("clr_y_vld", int'(y_vld), 1);
    check("clr_y_rec", int'(y_rec), 96);

    // T4 error bound: +4 per cycle once 100 emerges from the delay line
    d_ref = 8'd100;
    tick(11);
    check("bound_acc_32", int'(acc), 32);
    check("bound_flag_at_32", int'(err_flag), 0);
    check("bound_cnt_at_32", int'(err_cnt), 0);
    tick(1);
    check("bound_acc_36", int'(acc), 36);
    check("bound_flag_at_36", int'(err_flag), 1);
    check("bound_cnt_at_36", int'(err_cnt), 1);
    tick(4);
    check("bound_acc_52", int'(acc), 52);
    check("bound_cnt_5", int'(err_cnt), 5);

    // T6 en=0 freeze with changing inputs
    en    = 1'b0;
    d_ref = 8'd7;
    codes(2'b11, 2'b11, 2'b11, 2'b11);
    tick(5);
    check("frz_acc", int'(acc), 52);
    check("frz_err_cnt", int'(err_cnt), 5);
    check("frz_y_rec", int'(y_rec), 96);
    check("frz_y_vld", int'(y_vld), 1);
    en    = 1'b1;
    d_ref = 8'd100;
    codes(2'b00, 2'b00, 2'b11, 2'b11);
    tick(1);
    check("resume_acc", int'(acc), 56);
    check("resume_err_cnt", int'(err_cnt), 6);

    // Saturation: positive then negative
    d_ref = 8'd255;
    codes(2'b00, 2'b00, 2'b00, 2'b00);
    tick(20);
    check("sat_pos_acc", int'(acc), 2047);
    check("sat_pos_err_cnt", int'(err_cnt), 26);
    d_ref = 8'd0;
    codes(2'b11, 2'b11, 2'b11, 2'b11);
    tick(20);
    check("sat_neg_acc", int'(acc), -2047);
    check("sat_neg_err_cnt", int'(err_cnt), 46);
    check("sat_neg_y_rec", int'(y_rec), 480);

    // T5 imbalance
    clr = 1'b1;
    codes(2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    clr = 1'b0;
    check("clr2_err_flag", int'(err_flag), 0);
    check("clr2_err_cnt", int'(err_cnt), 0);
    d_out_0 = 2'b10;
    tick(2);
    check("imb_0_at_2", int'(imb_0), 2);
    check("imb_flag_at_2", int'(imb_flag), 0);
    tick(1);
    check("imb_0_at_3", int'(imb_0), 3);
    check("imb_flag_at_3", int'(imb_flag), 1);
    clr     = 1'b1;
    d_out_0 = 2'b00;
    tick(1);
    clr = 1'b0;
    check("clr3_imb_0", int'(imb_0), 0);
    for (int i = 0; i < 6; i++) begin
      d_out_0 = (i % 2 == 0) ? 2'b10 : 2'b01;
      tick(1);
      check("alt_imb_0", int'(imb_0), (i % 2 == 0) ? 1 : 0);
    end
    check("alt_imb_flag", int'(imb_flag), 0);

    // Reset mid-stream
    rst_b = 1'b0;
    tick(1);
    check("mid_rst_y_vld", int'(y_vld), 0);
    check("mid_rst_acc", int'(acc), 0);
    rst_b = 1'b1;
    tick(2);
    check("mid_fill2_y_vld", int'(y_vld), 0);
    tick(1);
    check("mid_fill3_y_vld", int'(y_vld), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
